// File: rtl/pwm_dac.sv
// pwm_dac: output stage of the synthesizer datapath.
// Converts the unsigned modulated sample into a single-bit PWM pin drive
// for an external RC low-pass filter. One sample is latched per PWM frame;
// a programmable tick prescaler sets the frame (audio sample) rate.
// Optional feature macro: PWM_DAC_NOISE_SHAPE_EN enables first-order
// error feedback of the discarded low sample bits.
module pwm_dac #(
  parameter int o = 16,  // incoming sample width
  parameter int P = 8,   // PWM resolution, frame = 2^P ticks (P < o)
  parameter int D = 8    // prescaler divide value width
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [D-1:0] div,
  input  logic [o-1:0] sample,
  output logic         pwm_out,
  output logic         frame,
  output logic [P-1:0] duty
);

  localparam logic [P-1:0] CNT_MAX = {P{1'b1}};

  logic [D-1:0] pcnt_q, pcnt_d;
  logic [P-1:0] cnt_q, cnt_d;
  logic [P-1:0] duty_q, duty_d;
  logic         pwm_q, pwm_d;
  logic         frame_q, frame_d;
  logic         tick;
  logic         frame_end;

  // >= rather than == so lowering div mid-count still ticks next clock.
  assign tick      = en & (pcnt_q >= div);
  assign frame_end = tick & (cnt_q == CNT_MAX);

`ifdef PWM_DAC_NOISE_SHAPE_EN
  localparam int RW = o - P;

  logic [RW-1:0] r_q, r_d;
  logic [o:0]    s_sum;

  // Saturate the duty on overflow of sample + residual.
  function automatic logic [P-1:0] sat_duty(input logic [o:0] s);
    return s[o] ? CNT_MAX : s[o-1:o-P];
  endfunction

  // Residual carried to the next frame; dropped when the sum saturates.
  function automatic logic [RW-1:0] next_residual(input logic [o:0] s);
    return s[o] ? '0 : s[RW-1:0];
  endfunction

  assign s_sum = {1'b0, sample} + {{(P + 1){1'b0}}, r_q};

  // Latch the shaped duty at frame end and carry the truncation error.
  always_comb begin
    duty_d = duty_q;
    r_d    = r_q;
    if (!en) begin
      r_d = '0;
    end else if (frame_end) begin
      duty_d = sat_duty(s_sum);
      r_d    = next_residual(s_sum);
    end
  end

  // Residual register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end
`else
  // Low sample bits are intentionally discarded in the unshaped build.
  logic unused_sample_lo;
  assign unused_sample_lo = ^sample[o-P-1:0];

  // Latch the top P bits of the sample at frame end.
  always_comb begin
    duty_d = duty_q;
    if (frame_end) begin
      duty_d = sample[o-1:o-P];
    end
  end
`endif

  // Prescaler, frame counter and registered PWM compare.
  always_comb begin
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    frame_d = 1'b0;
    if (!en) begin
      // Park cnt at frame end so the first tick after enable latches a sample.
      pcnt_d = '0;
      cnt_d  = CNT_MAX;
    end else if (tick) begin
      pcnt_d  = '0;
      cnt_d   = cnt_q + 1'b1;
      frame_d = frame_end;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end
    pwm_d = en & (cnt_d < duty_d);
  end

  // State registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q  <= '0;
      cnt_q   <= CNT_MAX;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
    end
  end

  assign pwm_out = pwm_q;
  assign frame   = frame_q;
  assign duty    = duty_q;

endmodule

// File: doc/pwm_dac.md
# pwm_dac

Output stage of the synthesizer datapath. It consumes the 16-bit unsigned modulated sample produced by the modulation stage and converts it to a single-bit PWM pin drive for an external RC low-pass filter. Each PWM frame latches one sample, so the frame rate is the effective audio sample rate. A programmable tick prescaler sets that rate. An optional first-order error-feedback path shapes the truncation noise of the discarded low bits.

## Interface

Parameters:
- `o`, 16, width of the incoming sample (matches the modulation stage output width).
- `P`, 8, PWM resolution in bits; a frame is 2^P ticks long; requires P < o.
- `D`, 8, width of the prescaler divide value.

Ports:
- `clk`, in, 1: system clock (50 MHz); all state is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: run enable.
- `div`, in, D: prescaler value; one tick every div+1 clocks.
- `sample`, in, o: unsigned sample from the modulation stage.
- `pwm_out`, out, 1: registered PWM output.
- `frame`, out, 1: one-clock pulse on the cycle a new sample is latched (sample-request strobe).
- `duty`, out, P: currently latched duty value.

## Operation

- **Prescaler.** `pcnt` (D bits) increments every clock while `en`=1.
  - `tick` = `en` & (`pcnt` >= `div`); on `tick`, `pcnt` returns to 0.
  - The >= compare keeps `tick` well-defined if `div` is lowered mid-count.
  - `div`=0 produces a tick every clock.
- **Frame counter.** `cnt` (P bits) increments on `tick`.
  - On `tick` with `cnt` = 2^P−1 (frame end), `cnt` wraps to 0.
  - On that same edge: `duty` latches the new value and `frame` pulses for one clock.
- **Duty without shaping.** `duty` = `sample[o-1:o-P]`.
- **PWM output.** `pwm_out` is registered: on each edge it is set to `en` & (next `cnt` < next `duty`).
  - Over one frame it is high for exactly `duty` ticks.
  - `duty`=0 gives constant low; `duty`=2^P−1 gives high for 2^P−1 of 2^P ticks.
- **`sample` sampling.** `sample` is sampled only at frame end; changes mid-frame have no effect until the next `frame`.
- **`en`=0.**
  - `pcnt`=0, `cnt`=2^P−1, `pwm_out`=0, `frame`=0.
  - `duty` holds its value; the residual (see Configuration) is cleared.
  - Because `cnt` is parked at 2^P−1, the first tick after `en` rises is a frame end: the sample is latched immediately and a frame starts.
- **Reset** (asynchronous, `rst_n`=0):
  - `pcnt`=0, `cnt`=2^P−1, `duty`=0, `pwm_out`=0, `frame`=0, residual=0.
  - Reset asserted mid-frame aborts the frame at once.
  - After release, behaviour matches the `en`=0 state.

## Timing

- Frame period: 2^P·(`div`+1) clocks. Default `div`=0 gives 256 clocks (195.3 kHz).
- Latency: `en` sampled high at edge k with `div`=0 → at edge k, `frame`=1, `duty`=`sample`, and `pwm_out` reflects `cnt`=0.
- `pwm_out` edges are aligned to ticks; the high time is `duty`·(`div`+1) clocks per frame.
- `frame` is high for exactly one clock per frame, regardless of `div`.
- A `div` change takes effect at the next prescaler compare; the current frame is never restarted.

## Configuration

- **Macro:** `PWM_DAC_NOISE_SHAPE_EN`.
- **Defined:**
  - An (o−P)-bit residual register `r` is added.
  - At frame end, `s` = `sample` + `r` is formed at o+1 bits.
  - If `s[o]`=1 (overflow): `duty`=2^P−1 and `r`=0 (saturate).
  - Otherwise: `duty`=`s[o-1:o-P]` and `r`=`s[o-P-1:0]`.
  - `r` is cleared by reset and by `en`=0.
- **Undefined:** no residual register; the low o−P bits of `sample` are discarded.

## Test plan

1. `div`=0, `sample`=0x8000, `en`=1 for 3 frames → `frame` every 256 clocks, `duty`=0x80, `pwm_out` high exactly 128 of each 256 clocks.
2. `sample`=0x0000, then 0xFFFF → `pwm_out` never high, then high 255 of 256 clocks per frame; `duty` = 0x00, then 0xFF.
3. `div`=3, `sample`=0x4000 → `frame` period 1024 clocks, `pwm_out` high 256 clocks per frame. Lower `div` from 3 to 1 while `pcnt`=3 → tick on the next clock, no lockup.
4. `sample` changed from 0x2000 to 0xC000 mid-frame → `duty` stays 0x20 until the next `frame` pulse, then becomes 0xC0.
5. `rst_n` pulsed low mid-frame → outputs go to 0 asynchronously, `duty`=0. After release with `en`=1, `div`=0: `frame` asserts on the first clock edge.
6. Noise shaping with `sample`=0x0080 held:
   - With `PWM_DAC_NOISE_SHAPE_EN` → `duty` alternates 0,1,0,1 across frames.
   - Without the macro → `duty` stays 0.
   - With the macro, `sample`=0xFFFF → `duty`=0xFF every frame (saturation on the second frame).
